// File: rtl/bcd_count_99_pkg.sv
// Shared constants, types and digit helpers for the two-digit BCD up/down counter.
package bcd_count_99_pkg;

    localparam int DIGIT_W      = 4;
    localparam int DIGIT_MAX    = 9;
    localparam int TICK_DIV_DEF = 50_000_000;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t tens;
        digit_t units;
    } bcd_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } count_op_e;

    localparam digit_t DIGIT_MAX_D = digit_t'(DIGIT_MAX);
    localparam bcd_t   BCD_ZERO    = '{tens: '0, units: '0};
    localparam bcd_t   BCD_TOP     = '{tens: DIGIT_MAX_D, units: DIGIT_MAX_D};

    function automatic digit_t clamp_digit(input digit_t d);
        return (d > DIGIT_MAX_D) ? DIGIT_MAX_D : d;
    endfunction

    function automatic bcd_t clamp_bcd(input logic [2*DIGIT_W-1:0] raw);
        bcd_t r;
        r.tens  = clamp_digit(raw[2*DIGIT_W-1:DIGIT_W]);
        r.units = clamp_digit(raw[DIGIT_W-1:0]);
        return r;
    endfunction

endpackage

// File: rtl/bcd_count_99_tick_gen.sv
// Free-running prescaler: emits one tick every TICK_DIV enabled cycles, parked at 0 while disabled.
module tick_gen
    import bcd_count_99_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TICK_W   = 26
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;
    logic              at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by reset so a tick can never coincide with a reset edge.
    assign tick_o = en_i & rst_ni & at_last;

endmodule

// File: rtl/bcd_count_99.sv
// Two-digit BCD counter 00..99 with direction, enable, clamped parallel load and wrap pulse.
module bcd_count_99
    import bcd_count_99_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TICK_W   = 26
) (
    input  logic                 fr_CLOCK_50,
    input  logic                 fr_RESET_N,
    input  logic                 fr_EN,
    input  logic                 fr_UP,
    input  logic                 fr_LOAD,
    input  logic [2*DIGIT_W-1:0] fr_SW,
    output logic [DIGIT_W-1:0]   to_BCD0,
    output logic [DIGIT_W-1:0]   to_BCD1,
    output logic                 to_WRAP,
    output logic                 to_TICK
);

    logic      tick;
    logic      load_q;
    logic      load_edge;
    bcd_t      count_q;
    bcd_t      count_d;
    logic      wrap_q;
    logic      wrap_d;
    count_op_e op;

    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.units == DIGIT_MAX_D) begin
            r.units = '0;
            r.tens  = (v.tens == DIGIT_MAX_D) ? '0 : v.tens + digit_t'(1);
        end else begin
            r.units = v.units + digit_t'(1);
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.units == '0) begin
            r.units = DIGIT_MAX_D;
            r.tens  = (v.tens == '0) ? DIGIT_MAX_D : v.tens - digit_t'(1);
        end else begin
            r.units = v.units - digit_t'(1);
        end
        return r;
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clk_i  (fr_CLOCK_50),
        .rst_ni (fr_RESET_N),
        .en_i   (fr_EN),
        .tick_o (tick)
    );

    assign load_edge = fr_LOAD & ~load_q;

    // Load has priority over a coincident tick; the dropped tick cannot wrap.
    always_comb begin
        op = OP_HOLD;
        if (load_edge) begin
            op = OP_LOAD;
        end else if (tick) begin
            op = fr_UP ? OP_UP : OP_DOWN;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (op)
            OP_LOAD: count_d = clamp_bcd(fr_SW);
            OP_UP: begin
                count_d = bcd_inc(count_q);
                wrap_d  = (count_q == BCD_TOP);
            end
            OP_DOWN: begin
                count_d = bcd_dec(count_q);
                wrap_d  = (count_q == BCD_ZERO);
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge fr_CLOCK_50) begin
        if (!fr_RESET_N) begin
            load_q  <= 1'b0;
            count_q <= BCD_ZERO;
            wrap_q  <= 1'b0;
        end else begin
            load_q  <= fr_LOAD;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign to_BCD0 = count_q.units;
    assign to_BCD1 = count_q.tens;
    assign to_WRAP = wrap_q;
    assign to_TICK = tick;

endmodule

// File: tb/tb_bcd_count_99.sv
// Self-checking bench for bcd_count_99 with a decimal-arithmetic reference model, TICK_DIV=4.
module tb_bcd_count_99;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] sw;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic       wrap;
    logic       tick;

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;

    // Reference model state: the count as a plain integer 0..99.
    int m_pre = 0;
    int m_val = 0;
    bit m_lq  = 1'b0;
    bit m_wrap = 1'b0;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] exp;
    } load_vec_t;

    load_vec_t lv [8];

    bcd_count_99 #(
        .TICK_DIV (TD),
        .TICK_W   (3)
    ) dut (
        .fr_CLOCK_50 (clk),
        .fr_RESET_N  (rst_n),
        .fr_EN       (en),
        .fr_UP       (up),
        .fr_LOAD     (load),
        .fr_SW       (sw),
        .to_BCD0     (bcd0),
        .to_BCD1     (bcd1),
        .to_WRAP     (wrap),
        .to_TICK     (tick)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit m_tick_now();
        return rst_n && en && (m_pre == TD - 1);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit edge_now;
        bit t;
        if (!rst_n) begin
            m_pre = 0; m_val = 0; m_lq = 1'b0; m_wrap = 1'b0;
        end else begin
            edge_now = load && !m_lq;
            t = m_tick_now();
            m_wrap = 1'b0;
            if (edge_now) begin
                m_val = clampd(int'(sw[7:4])) * 10 + clampd(int'(sw[3:0]));
            end else if (t) begin
                if (up) begin
                    m_wrap = (m_val == 99);
                    m_val = (m_val + 1) % 100;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val = (m_val + 99) % 100;
                end
            end
            m_pre = en ? (m_pre + 1) % TD : 0;
            m_lq = load;
        end
    endtask

    // One clock: check outputs on the falling edge, advance model on the rising edge.
    task automatic step();
        @(negedge clk);
        chk("count", {bcd1, bcd0}, to_bcd(m_val));
        chk("wrap", {7'd0, wrap}, {7'd0, m_wrap});
        chk("tick", {7'd0, tick}, {7'd0, m_tick_now()});
        if (tick === 1'b1) tick_cnt++;
        if (wrap === 1'b1) wrap_cnt++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [7:0] v);
        en = 1'b0; load = 1'b1; sw = v;
        step();
        load = 1'b0;
        step();
    endtask

    initial begin
        int t0;
        int w0;
        lv[0] = '{8'h98, 8'h98};
        lv[1] = '{8'hFA, 8'h99};
        lv[2] = '{8'h5C, 8'h59};
        lv[3] = '{8'hA3, 8'h93};
        lv[4] = '{8'hFF, 8'h99};
        lv[5] = '{8'h00, 8'h00};
        lv[6] = '{8'h09, 8'h09};
        lv[7] = '{8'hB0, 8'h90};

        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; sw = 8'h77;
        @(posedge clk);
        #1;
        run(2);

        // Free count up for 40 cycles.
        rst_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
        t0 = tick_cnt;
        run(40);
        en = 1'b0;
        step();
        chk("count_after_40", {bcd1, bcd0}, 8'h10);
        chk("ticks_in_40", 8'(tick_cnt - t0), 8'd10);

        // Clamped load table.
        for (int i = 0; i < 8; i++) begin
            do_load(lv[i].sw);
            chk($sformatf("load_%0h", lv[i].sw), {bcd1, bcd0}, lv[i].exp);
        end

        // Up across 99 -> 00.
        do_load(8'h98);
        w0 = wrap_cnt;
        en = 1'b1; up = 1'b1;
        run(8);
        en = 1'b0;
        step();
        chk("up_wrap_val", {bcd1, bcd0}, 8'h00);
        chk("up_wrap_cnt", 8'(wrap_cnt - w0), 8'd1);

        // Down across 00 -> 99.
        do_load(8'h01);
        w0 = wrap_cnt;
        en = 1'b1; up = 1'b0;
        run(12);
        en = 1'b0;
        step();
        chk("down_wrap_val", {bcd1, bcd0}, 8'h98);
        chk("down_wrap_cnt", 8'(wrap_cnt - w0), 8'd1);

        // Held load: only the first edge loads.
        en = 1'b0; load = 1'b1; sw = 8'h33;
        step();
        sw = 8'h77;
        run(19);
        load = 1'b0;
        step();
        chk("held_load", {bcd1, bcd0}, 8'h33);

        // Load edge coincident with a tick.
        en = 1'b1; up = 1'b1;
        run(3);
        load = 1'b1; sw = 8'h42;
        step();
        load = 1'b0; en = 1'b0;
        step();
        chk("load_vs_tick", {bcd1, bcd0}, 8'h42);
        chk("load_vs_tick_wrap", {7'd0, wrap}, 8'd0);
        t0 = tick_cnt;
        run(10);
        chk("paused_ticks", 8'(tick_cnt - t0), 8'd0);
        chk("paused_count", {bcd1, bcd0}, 8'h42);

        // Reset mid-prescale at 57.
        do_load(8'h57);
        en = 1'b1; up = 1'b1;
        run(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset_mid", {bcd1, bcd0}, 8'h00);
        t0 = tick_cnt;
        run(3);
        chk("no_tick_before_4", 8'(tick_cnt - t0), 8'd0);
        step();
        chk("tick_at_4", 8'(tick_cnt - t0), 8'd1);

        // Load already high at reset release loads once.
        en = 1'b0; rst_n = 1'b0; load = 1'b1; sw = 8'h25;
        step();
        rst_n = 1'b1;
        step();
        sw = 8'h61;
        step();
        chk("load_at_release", {bcd1, bcd0}, 8'h25);
        load = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            en    = ($urandom_range(0, 7) != 0);
            up    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 5) == 0) load = ~load;
            sw    = 8'($urandom());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_count_99.md
BCD_COUNT_99 -- requirements
Module: bcd_count_99

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: clock cycles per count tick; legal range 2..2^26.
REQ-002 SHALL have parameter TICK_W, default 26: prescaler width; SHALL satisfy 2^TICK_W >= TICK_DIV.
REQ-003 fr_CLOCK_50  input  1  single system clock; all logic is clocked on its rising edge.
REQ-004 fr_RESET_N  input  1  reset; synchronous and active-low.
REQ-005 fr_EN  input  1  count enable, level; 1 = run, 0 = pause.
REQ-006 fr_UP  input  1  direction; 1 = up, 0 = down.
REQ-007 fr_LOAD  input  1  load request, level; acted on at its rising edge only.
REQ-008 fr_SW  input  8  load value: [7:4] tens digit, [3:0] units digit, BCD.
REQ-009 to_BCD0  output  4  units digit; drives char_7seg BCD input of HEX0.
REQ-010 to_BCD1  output  4  tens digit; drives char_7seg BCD input of HEX1.
REQ-011 to_WRAP  output  1  one-cycle pulse on wrap-around (99->00 up, 00->99 down).
REQ-012 to_TICK  output  1  one-cycle pulse on each prescaler tick; for LED and bench visibility.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while fr_EN=1, then return to 0.
REQ-014 to_TICK SHALL be 1 for exactly the one cycle in which the prescaler equals TICK_DIV-1 and fr_EN=1.
REQ-015 While fr_EN=0, the prescaler SHALL hold at 0 and to_TICK SHALL be 0; counting resumes a full TICK_DIV cycles after fr_EN returns to 1.
REQ-016 Rising edge of fr_LOAD SHALL be detected against a registered copy of fr_LOAD; a level held high SHALL cause exactly one load.
REQ-017 Load SHALL update to_BCD1/to_BCD0 one cycle after the edge-detect cycle; load latency is 1 cycle from the first sampled high.
REQ-018 On load, any fr_SW digit greater than 9 SHALL be clamped to 9 per digit; for example, 8'hA3 loads 93 and 8'hFF loads 99.
REQ-019 On a tick, the count SHALL go up by one in BCD when fr_UP=1 and down by one when fr_UP=0; the digit update is visible the cycle after to_TICK.
REQ-020 Up: units 9->0 with a carry into tens; 99 SHALL become 00 and to_WRAP SHALL pulse.
REQ-021 Down: units 0->9 with a borrow from tens; 00 SHALL become 99 and to_WRAP SHALL pulse.
REQ-022 to_WRAP SHALL be registered and asserted in the same cycle the wrapped value first appears on the outputs.
REQ-023 If a load edge and a tick occur in the same cycle, the load SHALL win, the tick SHALL be dropped and to_WRAP SHALL be 0.
REQ-024 The prescaler SHALL be unaffected by a load and keep running.
REQ-025 Each to_BCD digit SHALL always be in the range 0..9; no code 10..15 ever appears on the outputs.
REQ-026 A change of fr_UP SHALL take effect on the next tick; no glitch and no extra step.

Reset
REQ-027 While fr_RESET_N=0 at a clock edge: to_BCD1=0, to_BCD0=0, to_WRAP=0, to_TICK=0, prescaler=0, registered fr_LOAD=0.
REQ-028 Reset SHALL override load and tick in the same cycle.
REQ-029 Reset asserted mid-count SHALL restart the prescaler from 0 on the first cycle after release.
REQ-030 If fr_LOAD is already high when reset is released, that SHALL count as a rising edge and load once.

Structure
REQ-031 The shared package SHALL hold the BCD digit width (4), the maximum digit value (9) and the TICK_DIV default.
REQ-032 The prescaler SHALL be a separate sub-module named tick_gen, with ports clock, reset, enable and tick pulse, parameterised by TICK_DIV.
REQ-033 The BCD increment/decrement SHALL be purely combinational next-state logic inside bcd_count_99, with all outputs registered.
REQ-034 The top level SHALL connect to_BCD0 and to_BCD1 to two char_7seg instances; that wiring is outside this module.

Verification
All scenarios run with TICK_DIV=4.
REQ-035 Reset, then fr_EN=1, fr_UP=1 for 40 cycles -> outputs read 00, 01, ... 10 with one step every 4 cycles; to_TICK has period 4.
REQ-036 Load 8'h98 with fr_UP=1, then 2 ticks -> 98, 99, 00; to_WRAP pulses once, aligned with 00.
REQ-037 Load 8'h01 with fr_UP=0, then 3 ticks -> 01, 00, 99, 98; to_WRAP pulses once, aligned with 99.
REQ-038 Load 8'hFA -> count reads 99; load 8'h5C -> count reads 59; hold fr_LOAD high for 20 cycles -> exactly one load.
REQ-039 Drive the fr_LOAD edge in the same cycle as to_TICK, with value 8'h42 -> count reads 42, no step and to_WRAP=0; then fr_EN=0 for 10 cycles -> count frozen and to_TICK=0.
REQ-040 Assert fr_RESET_N=0 for 1 cycle at count 57 mid-prescale -> outputs 00 the next cycle; first tick comes 4 cycles after release.
